// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Loads a short program from a host and issues it, one word per
//            clock, to the 4-bit calculator while collecting readback results.
// Revision : 1.0
// ============================================================================
module calc_sequencer #(
  parameter int DEPTH = 8,
  parameter int IW    = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_valid,
  output logic                     prog_ready,
  input  logic [IW-1:0]            prog_data,
  input  logic                     prog_clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               calc_control,
  output logic [1:0]               calc_we_addr,
  output logic [1:0]               calc_rd_addr,
  output logic [3:0]               calc_immediate,
  input  logic [3:0]               calc_rd_data,
  output logic                     res_valid,
  output logic [3:0]               res_data,
  output logic [$clog2(DEPTH)-1:0] res_index
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  // r0 = r0 OR 0: leaves the register file untouched on every falling edge
  localparam logic [IW-1:0] c_NOP = {3'b001, {(IW-3){1'b0}}};

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_CW-1:0] r_count;
  logic [c_AW-1:0] r_pc;
  logic [IW-1:0]   r_mem [DEPTH];
  logic [IW-1:0]   r_calc;
  logic            r_iss_valid;
  logic [c_AW-1:0] r_iss_idx;

  logic            w_go;
  logic            w_clear;
  logic            w_load;
  logic            w_last;
  logic            w_issue;
  logic            w_done_nxt;
  logic [IW-1:0]   w_calc_nxt;

  assign w_go    = (r_state == c_IDLE) && start && (r_count != '0);
  assign w_clear = (r_state == c_IDLE) && prog_clear;
  assign w_last  = ({1'b0, r_pc} == (r_count - c_CW'(1)));

  assign prog_ready = (r_state == c_IDLE) && (r_count < c_CW'(DEPTH)) &&
                      !prog_clear && !w_go;
  assign w_load     = prog_valid && prog_ready;

  assign calc_control   = r_calc[10:8];
  assign calc_we_addr   = r_calc[7:6];
  assign calc_rd_addr   = r_calc[5:4];
  assign calc_immediate = r_calc[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_go) w_state_nxt = c_RUN;
      c_RUN:   if (w_last) w_state_nxt = c_DRAIN;
      c_DRAIN: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_issue    = (r_state == c_RUN);
    w_done_nxt = (r_state == c_DRAIN);
    busy       = (r_state == c_RUN) || (r_state == c_DRAIN);
    w_calc_nxt = w_issue ? r_mem[r_pc] : c_NOP;
  end

  // Program storage carries no reset; its contents are meaningless until loaded
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[r_count[c_AW-1:0]] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_pc        <= '0;
      r_calc      <= c_NOP;
      r_iss_valid <= 1'b0;
      r_iss_idx   <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
      done        <= 1'b0;
    end else begin
      if (w_clear) begin
        r_count <= '0;
      end else if (w_load) begin
        r_count <= r_count + c_CW'(1);
      end

      if (w_go) begin
        r_pc <= '0;
      end else if (w_issue) begin
        r_pc <= r_pc + c_AW'(1);
      end

      r_calc      <= w_calc_nxt;
      r_iss_valid <= w_issue;
      r_iss_idx   <= r_pc;
      // The word issued last edge was written on the falling edge in between
      res_valid   <= r_iss_valid;
      if (r_iss_valid) begin
        res_data  <= calc_rd_data;
        res_index <= r_iss_idx;
      end
      done <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire
